// File: rtl/dmi_jtag_req_tracker.sv
// Sequencer between the JTAG DTM dmi data register and the debug-module interface:
// one valid/ready request per accepted DR update, response latched for the next capture.
module dmi_jtag_req_tracker #(
  parameter int ABITS = 7,
  parameter int DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_dr_i,
  input  logic             capture_dr_i,
  input  logic             dmi_reset_i,
  input  logic [ABITS-1:0] scan_addr_i,
  input  logic [DBITS-1:0] scan_data_i,
  input  logic [1:0]       scan_op_i,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [DBITS-1:0] dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [DBITS-1:0] dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_op_i,
  output logic [DBITS-1:0] capture_data_o,
  output logic [1:0]       error_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_FAILED = 2'd2;
  localparam logic [1:0] ERR_BUSY   = 2'd3;

  state_t     state;
  state_t     state_next;
  logic       launch;
  logic       resp_fire;
  logic       violation;
  logic [1:0] error_next;

  assign launch    = (state == S_IDLE) && update_dr_i && (error_o == ERR_NONE) &&
                     ((scan_op_i == OP_READ) || (scan_op_i == OP_WRITE));
  assign resp_fire = (state == S_WAIT) && dmi_resp_valid_i;
  // A scan touching the dmi register while a transaction is in flight is dropped.
  assign violation = (state != S_IDLE) && (update_dr_i || capture_dr_i);

  // NOTE: the reset is synchronous, so rst_i is only tested inside the clocked block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge values.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through this block leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      S_IDLE:  if (launch)           state_next = S_REQ;
      S_REQ:   if (dmi_req_ready_i)  state_next = S_WAIT;
      S_WAIT:  if (dmi_resp_valid_i) state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // First error wins; a failed response outranks a busy violation in the same cycle,
  // and dmireset outranks both.
  always_comb begin
    error_next = error_o;
    if (error_o == ERR_NONE) begin
      if (resp_fire && (dmi_resp_op_i != ERR_NONE)) begin
        error_next = (dmi_resp_op_i == ERR_BUSY) ? ERR_BUSY : ERR_FAILED;
      end else if (violation) begin
        error_next = ERR_BUSY;
      end
    end
    if (dmi_reset_i) begin
      error_next = ERR_NONE;
    end
  end

  // Handshake flags come straight from flops, decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      dmi_req_valid_o  <= (state_next == S_REQ);
      dmi_resp_ready_o <= (state_next == S_WAIT);
      busy_o           <= (state_next != S_IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmi_req_addr_o <= '0;
      dmi_req_data_o <= '0;
      dmi_req_op_o   <= 2'd0;
      capture_data_o <= '0;
      error_o        <= ERR_NONE;
    end else begin
      if (launch) begin
        dmi_req_addr_o <= scan_addr_i;
        dmi_req_data_o <= scan_data_i;
        dmi_req_op_o   <= scan_op_i;
      end
      if (resp_fire) begin
        capture_data_o <= dmi_resp_data_i;
      end
      error_o <= error_next;
    end
  end

endmodule

// File: tb/tb_dmi_jtag_req_tracker.sv
// Bench for dmi_jtag_req_tracker: directed scenarios then random traffic, checked
// against a transaction-phase reference model through request/completion scoreboards.
module tb_dmi_jtag_req_tracker;

  localparam int ABITS = 7;
  localparam int DBITS = 32;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             update_dr_i = 1'b0;
  logic             capture_dr_i = 1'b0;
  logic             dmi_reset_i = 1'b0;
  logic [ABITS-1:0] scan_addr_i = '0;
  logic [DBITS-1:0] scan_data_i = '0;
  logic [1:0]       scan_op_i = 2'd0;
  logic             dmi_req_valid_o;
  logic             dmi_req_ready_i = 1'b0;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [DBITS-1:0] dmi_req_data_o;
  logic [1:0]       dmi_req_op_o;
  logic             dmi_resp_valid_i = 1'b0;
  logic             dmi_resp_ready_o;
  logic [DBITS-1:0] dmi_resp_data_i = '0;
  logic [1:0]       dmi_resp_op_i = 2'd0;
  logic [DBITS-1:0] capture_data_o;
  logic [1:0]       error_o;
  logic             busy_o;

  dmi_jtag_req_tracker #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .update_dr_i      (update_dr_i),
    .capture_dr_i     (capture_dr_i),
    .dmi_reset_i      (dmi_reset_i),
    .scan_addr_i      (scan_addr_i),
    .scan_data_i      (scan_data_i),
    .scan_op_i        (scan_op_i),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_req_addr_o   (dmi_req_addr_o),
    .dmi_req_data_o   (dmi_req_data_o),
    .dmi_req_op_o     (dmi_req_op_o),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .dmi_resp_data_i  (dmi_resp_data_i),
    .dmi_resp_op_i    (dmi_resp_op_i),
    .capture_data_o   (capture_data_o),
    .error_o          (error_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] data;
    logic [1:0]       op;
  } req_t;

  typedef struct {
    logic [DBITS-1:0] data;
    logic [1:0]       err;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  done_t d_item;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit rst_applied = 1'b1;
  bit busy_prev = 1'b0;

  int               m_phase = PH_IDLE;
  logic [1:0]       m_err = 2'd0;
  logic [1:0]       err_before;
  logic [1:0]       cand;
  logic [DBITS-1:0] m_cap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry queued at %0t", name, $time);
  endtask

  // Reference model: a transaction is issued, handed to the debug module, then answered.
  // Error is the first nonzero cause seen while no error is held; dmireset wins.
  always @(posedge clk) begin
    if (rst_i) begin
      m_phase = PH_IDLE;
      m_err   = 2'd0;
      m_cap   = '0;
      req_q.delete();
      done_q.delete();
    end else begin
      err_before = m_err;
      cand = 2'd0;
      if (m_phase == PH_WAIT && dmi_resp_valid_i && dmi_resp_op_i != 2'd0)
        cand = (dmi_resp_op_i == 2'd3) ? 2'd3 : 2'd2;
      else if (m_phase != PH_IDLE && (update_dr_i || capture_dr_i))
        cand = 2'd3;
      if (m_err == 2'd0) m_err = cand;
      if (dmi_reset_i) m_err = 2'd0;
      if (m_phase == PH_IDLE) begin
        if (update_dr_i && err_before == 2'd0 && (scan_op_i == 2'd1 || scan_op_i == 2'd2)) begin
          req_q.push_back('{scan_addr_i, scan_data_i, scan_op_i});
          m_phase = PH_REQ;
        end
      end else if (m_phase == PH_REQ) begin
        if (dmi_req_ready_i) m_phase = PH_WAIT;
      end else if (dmi_resp_valid_i) begin
        m_cap = dmi_resp_data_i;
        done_q.push_back('{m_cap, m_err});
        m_phase = PH_IDLE;
      end
    end
  end

  // Monitor: inputs change just after posedge, so at negedge everything is settled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_applied) begin
        check("rst_valid", 64'(dmi_req_valid_o), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_capture", 64'(capture_data_o), 64'd0);
        check("rst_req_addr", 64'(dmi_req_addr_o), 64'd0);
        check("rst_req_data", 64'(dmi_req_data_o), 64'd0);
        check("rst_req_op", 64'(dmi_req_op_o), 64'd0);
      end else begin
        check("busy", 64'(busy_o), 64'(m_phase != PH_IDLE));
        check("req_valid", 64'(dmi_req_valid_o), 64'(m_phase == PH_REQ));
        check("resp_ready", 64'(dmi_resp_ready_o), 64'(m_phase == PH_WAIT));
        check("error", 64'(error_o), 64'(m_err));
        if (dmi_req_valid_o) begin
          if (req_q.size() == 0) begin
            report_missing("req_unexpected");
          end else begin
            check("req_addr", 64'(dmi_req_addr_o), 64'(req_q[0].addr));
            check("req_data", 64'(dmi_req_data_o), 64'(req_q[0].data));
            check("req_op", 64'(dmi_req_op_o), 64'(req_q[0].op));
            if (dmi_req_ready_i) void'(req_q.pop_front());
          end
        end
        if (busy_prev && !busy_o) begin
          if (done_q.size() == 0) begin
            report_missing("done_unexpected");
          end else begin
            d_item = done_q.pop_front();
            check("done_capture", 64'(capture_data_o), 64'(d_item.data));
            check("done_error", 64'(error_o), 64'(d_item.err));
          end
        end
      end
      busy_prev = busy_o;
    end
    rst_applied = rst_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one update pulse; returns in the cycle after it (request visible if accepted).
  task automatic issue(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d);
    step();
    update_dr_i = 1'b1;
    scan_op_i   = op;
    scan_addr_i = a;
    scan_data_i = d;
    step();
    update_dr_i = 1'b0;
  endtask

  // Full transaction with ready held high and the response in the first WAIT cycle.
  task automatic xact(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [DBITS-1:0] d,
                      input logic [DBITS-1:0] rdata, input logic [1:0] rop);
    dmi_req_ready_i = 1'b1;
    issue(op, a, d);
    step();
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = rdata;
    dmi_resp_op_i    = rop;
    step();
    dmi_resp_valid_i = 1'b0;
  endtask

  task automatic pulse_dmireset();
    step();
    dmi_reset_i = 1'b1;
    step();
    dmi_reset_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    dmi_req_ready_i = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;
    step();
    rst_i = 1'b0;

    // Read with no stalls: valid at N+1, result at N+3.
    issue(2'd1, 7'h11, 32'h0);
    @(negedge clk);
    check("read_valid_n1", 64'(dmi_req_valid_o), 64'd1);
    check("read_addr_n1", 64'(dmi_req_addr_o), 64'h11);
    step();
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'hDEADBEEF;
    dmi_resp_op_i    = 2'd0;
    step();
    dmi_resp_valid_i = 1'b0;
    @(negedge clk);
    check("read_capture_n3", 64'(capture_data_o), 64'hDEADBEEF);
    check("read_busy_n3", 64'(busy_o), 64'd0);
    check("read_error_n3", 64'(error_o), 64'd0);

    // Write stalled for five cycles: valid held six cycles with stable fields.
    dmi_req_ready_i = 1'b0;
    issue(2'd2, 7'h05, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(dmi_req_valid_o), 64'd1);
      check("stall_data", 64'(dmi_req_data_o), 64'h12345678);
      step();
    end
    dmi_req_ready_i = 1'b1;
    @(negedge clk);
    check("stall_valid_last", 64'(dmi_req_valid_o), 64'd1);
    step();
    dmi_req_ready_i  = 1'b0;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'hA5A5A5A5;
    dmi_resp_op_i    = 2'd0;
    @(negedge clk);
    check("stall_valid_drop", 64'(dmi_req_valid_o), 64'd0);
    step();
    dmi_resp_valid_i = 1'b0;
    @(negedge clk);
    check("write_error", 64'(error_o), 64'd0);

    // Failed op: sticky error blocks the next update until dmireset.
    xact(2'd1, 7'h22, 32'h0, 32'hCAFE0001, 2'd2);
    @(negedge clk);
    check("failed_error", 64'(error_o), 64'd2);
    issue(2'd1, 7'h23, 32'h0);
    @(negedge clk);
    check("blocked_valid", 64'(dmi_req_valid_o), 64'd0);
    check("blocked_busy", 64'(busy_o), 64'd0);
    pulse_dmireset();
    @(negedge clk);
    check("dmireset_error", 64'(error_o), 64'd0);
    xact(2'd1, 7'h24, 32'h0, 32'h0BADF00D, 2'd0);
    @(negedge clk);
    check("reissue_capture", 64'(capture_data_o), 64'h0BADF00D);

    // Busy violation in WAIT, then a failing response keeps the busy code.
    dmi_req_ready_i = 1'b1;
    issue(2'd2, 7'h30, 32'h11112222);
    step();
    update_dr_i = 1'b1;
    scan_op_i   = 2'd2;
    scan_addr_i = 7'h31;
    step();
    update_dr_i = 1'b0;
    @(negedge clk);
    check("viol_error", 64'(error_o), 64'd3);
    check("viol_no_req", 64'(dmi_req_valid_o), 64'd0);
    check("viol_busy", 64'(busy_o), 64'd1);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = 32'h00000033;
    dmi_resp_op_i    = 2'd2;
    step();
    dmi_resp_valid_i = 1'b0;
    @(negedge clk);
    check("viol_sticky", 64'(error_o), 64'd3);
    check("viol_capture", 64'(capture_data_o), 64'h33);
    pulse_dmireset();

    // dmireset together with a busy-violating capture, then reset while in REQ.
    dmi_req_ready_i = 1'b0;
    issue(2'd1, 7'h40, 32'h0);
    capture_dr_i = 1'b1;
    dmi_reset_i  = 1'b1;
    step();
    capture_dr_i = 1'b0;
    dmi_reset_i  = 1'b0;
    @(negedge clk);
    check("simul_error", 64'(error_o), 64'd0);
    check("simul_valid", 64'(dmi_req_valid_o), 64'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(dmi_req_valid_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_capture", 64'(capture_data_o), 64'd0);

    // Random traffic on every input.
    for (int n = 0; n < 4000; n++) begin
      step();
      rst_i            = ($urandom_range(299) == 0);
      update_dr_i      = ($urandom_range(5) == 0);
      capture_dr_i     = ($urandom_range(9) == 0);
      dmi_reset_i      = ($urandom_range(24) == 0);
      scan_op_i        = 2'($urandom_range(3));
      scan_addr_i      = 7'($urandom);
      scan_data_i      = $urandom;
      dmi_req_ready_i  = $urandom_range(1) == 1;
      dmi_resp_valid_i = ($urandom_range(2) == 0);
      dmi_resp_data_i  = $urandom;
      dmi_resp_op_i    = 2'($urandom_range(3));
    end
    step();
    rst_i = 1'b0;
    update_dr_i = 1'b0;
    capture_dr_i = 1'b0;
    dmi_reset_i = 1'b0;
    dmi_req_ready_i = 1'b1;
    dmi_resp_valid_i = 1'b1;
    dmi_resp_op_i = 2'd0;
    repeat (4) step();
    @(negedge clk);
    check("drain_busy", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmi_jtag_req_tracker.md
# dmi_jtag_req_tracker

Request/response sequencer between the JTAG DTM data register and the debug-module interface (DMI). It takes a captured `dmi` DR scan on `update_dr_i`, issues one valid/ready request to the debug module and waits for the response. It then latches the read data for the next `capture_dr_i` and maintains the sticky `dmistat` error code, which is cleared by the dtmcs `dmireset` pulse.

## Interface
- `ABITS`, default 7: DMI address width.
- `DBITS`, default 32: DMI data width.

Clock and reset are one clock with a synchronous, active-high reset.

- `clk_i` input 1: clock, all state on its rising edge.
- `rst_i` input 1: synchronous active-high reset.
- `update_dr_i` input 1: one-cycle pulse, the `dmi` DR update with the `dmi` register selected.
- `capture_dr_i` input 1: one-cycle pulse, the `dmi` DR capture.
- `dmi_reset_i` input 1: one-cycle pulse from a dtmcs write with `dmireset=1`.
- `scan_addr_i` input ABITS: scanned address.
- `scan_data_i` input DBITS: scanned write data.
- `scan_op_i` input 2: scanned op (0 nop, 1 read, 2 write, 3 reserved).
- `dmi_req_valid_o` output 1: request valid.
- `dmi_req_ready_i` input 1: debug module accepts the request.
- `dmi_req_addr_o` output ABITS: request address.
- `dmi_req_data_o` output DBITS: request data.
- `dmi_req_op_o` output 2: request op (1 or 2 only).
- `dmi_resp_valid_i` input 1: response valid.
- `dmi_resp_ready_o` output 1: tracker accepts the response.
- `dmi_resp_data_i` input DBITS: response data.
- `dmi_resp_op_i` input 2: response status (0 ok, 2 failed, 3 busy).
- `capture_data_o` output DBITS: data presented to the DR on capture.
- `error_o` output 2: sticky error (0 none, 2 op failed, 3 busy).
- `busy_o` output 1: transaction outstanding.

## Operation
- **States.** IDLE, REQ, WAIT.
- **Reset.** State is IDLE. All outputs are 0, including `capture_data_o`, `error_o`, the request fields, `dmi_req_valid_o` and `dmi_resp_ready_o`.
- **IDLE to REQ.** Taken on `update_dr_i` when `error_o==0` and `scan_op_i` is 1 or 2.
  - Latch the addr, data and op fields.
  - `dmi_req_valid_o` becomes 1.
- **Ignored updates in IDLE.** `update_dr_i` with op 0 or 3, or with `error_o!=0`, issues no request. State and latched fields are unchanged.
- **REQ.** `dmi_req_valid_o=1` with request fields stable until `dmi_req_ready_i`. On the handshake go to WAIT.
- **WAIT.** `dmi_resp_ready_o=1`. On `dmi_resp_valid_i`:
  - `capture_data_o <= dmi_resp_data_i` for both reads and writes.
  - If `dmi_resp_op_i!=0` and `error_o==0`, then `error_o <= dmi_resp_op_i`; a response op of 1 is recorded as 2.
  - Go to IDLE.
- **`busy_o`.** Equals `state!=IDLE`.
- **Busy violation.** `update_dr_i` or `capture_dr_i` while `busy_o=1` sets `error_o<=3` if `error_o==0`. The scan request is dropped; the in-flight transaction continues unaffected.
- **Sticky error.** `error_o` changes only via the rules above, via `dmi_reset_i` or via reset. The first error recorded is kept.
- **`dmi_reset_i`.**
  - Clears `error_o` to 0.
  - Does not abort REQ or WAIT.
  - Clear has priority over any error set in the same cycle.
- **Capture behaviour.** `capture_dr_i` in IDLE has no state effect; `capture_data_o` already holds the last response.
- **Reset mid-transaction.** `rst_i` in REQ or WAIT returns to IDLE immediately, and a pending response is not consumed.

## Timing
- **Request launch.** `update_dr_i` at cycle N gives `dmi_req_valid_o=1` at N+1.
- **Minimum round trip.**
  - With ready high at N+1, state is WAIT at N+2.
  - With `dmi_resp_valid_i` at N+2, `capture_data_o`/`error_o` update and `busy_o=0` at N+3.
- **Cycle-exact behaviour.** The request holds for any number of stall cycles; there is no timeout. Response valid may arrive in the same cycle the tracker enters WAIT; it is sampled only while in WAIT.
- **Registered outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Read, no stalls.** Reset, then `update_dr_i` with op=1, addr=0x11. Ready is held high; the response (data 0xDEADBEEF, op 0) arrives in the first WAIT cycle.
  - Required: valid at N+1 with addr 0x11, `capture_data_o=0xDEADBEEF` at N+3, `error_o=0`, `busy_o=0` at N+3.
- **Stalled write.** op=2, data 0x12345678, ready low for 5 cycles.
  - Required: valid high for 6 cycles with fields stable.
  - Response op 0 gives `error_o=0`.
- **Failed op.** Response op=2.
  - Required: `error_o=2`.
  - A following `update_dr_i` op=1 produces no `dmi_req_valid_o`.
  - `dmi_reset_i` gives `error_o=0`; the next read then issues normally.
- **Busy violation.** `update_dr_i` op=2 while in WAIT.
  - Required: `error_o=3` next cycle, with no second request.
  - A later response op=2 leaves `error_o=3`.
- **Simultaneous events.** `dmi_reset_i` in the same cycle as a busy-violating `capture_dr_i`: `error_o=0`.
  - `rst_i` asserted in REQ: all outputs 0 the next cycle and state IDLE.
